// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : single-outstanding instruction fetch with redirect and stall
// Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [15:0] COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [6:0]  opcode_q;
  logic [31:0] pc_out_q;
  logic [15:0] count_q;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  // Request is gated by rst_n so nothing is issued while reset is asserted.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = opcode_q;
  assign pc_out      = pc_out_q;
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      opcode_q      <= 7'h0;
      pc_out_q      <= 32'h0;
      count_q       <= COUNT_INIT;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q <= S_WAIT;
          if (redirect) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q <= redirect_tgt;
            if (imem_rvalid) begin
              kill_q  <= 1'b0;
              state_q <= S_FETCH;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= S_FETCH;
            end else begin
              instr_q       <= imem_rdata;
              opcode_q      <= imem_rdata[6:0];
              pc_out_q      <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Redirect wins over consumption: the held instruction is dropped uncounted.
          if (redirect) begin
            pc_q          <= redirect_tgt;
            instr_valid_q <= 1'b0;
            state_q       <= S_FETCH;
          end else if (!stall) begin
            pc_q          <= pc_q + 32'd4;
            count_q       <= count_q + 16'd1;
            instr_valid_q <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic [15:0] instr_count;

  // Second instance: PC and counter wrap-around, fed by a 1-cycle memory.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_rvalid;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [31:0] w_pc;
  logic [15:0] w_cnt;

  int n_checks;
  int n_errors;

  fetch_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .instr_count (instr_count)
  );

  fetch_unit #(
    .RESET_PC   (32'hFFFF_FFFC),
    .COUNT_INIT (16'hFFFF)
  ) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rdata  (w_rdata),
    .imem_rvalid (w_rvalid),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .stall       (1'b0),
    .instr_valid (w_valid),
    .instr       (w_instr),
    .opcode      (w_opcode),
    .pc_out      (w_pc),
    .instr_count (w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_rdata = 32'h0000_0013;
  always @(posedge clk) w_rvalid <= w_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req",    {31'h0, imem_req},    32'h0);
    check("rst_valid",  {31'h0, instr_valid}, 32'h0);
    check("rst_count",  {16'h0, instr_count}, 32'h0);
    check("rst_pcout",  pc_out,               32'h0);
    check("rst_instr",  instr,                32'h0);
    check("rst_opcode", {25'h0, opcode},      32'h0);
    check("w_rst_cnt",  {16'h0, w_cnt},       32'h0000_FFFF);

    // Cycle 1 after release: FETCH at RESET_PC
    rst_n = 1'b1;
    #1;
    check("c1_req",    {31'h0, imem_req}, 32'h1);
    check("c1_addr",   imem_addr,         32'h0);
    check("w_c1_addr", w_addr,            32'hFFFF_FFFC);
    @(negedge clk); // cycle 2: WAIT, 1-cycle response
    check("c2_req",   {31'h0, imem_req},    32'h0);
    check("c2_valid", {31'h0, instr_valid}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    @(negedge clk); // cycle 3: HOLD
    imem_rvalid = 1'b0;
    check("c3_valid",  {31'h0, instr_valid}, 32'h1);
    check("c3_opcode", {25'h0, opcode},      32'h0000_0033);
    check("c3_instr",  instr,                32'h0000_0033);
    check("c3_pcout",  pc_out,               32'h0);
    check("c3_count",  {16'h0, instr_count}, 32'h0);
    check("w_c3_valid", {31'h0, w_valid},    32'h1);
    check("w_c3_cnt",   {16'h0, w_cnt},      32'h0000_FFFF);
    @(negedge clk); // cycle 4: consumed, FETCH at 4
    check("c4_req",   {31'h0, imem_req},    32'h1);
    check("c4_addr",  imem_addr,            32'h4);
    check("c4_count", {16'h0, instr_count}, 32'h1);
    check("c4_valid", {31'h0, instr_valid}, 32'h0);
    check("w_c4_cnt",  {16'h0, w_cnt},      32'h0);
    check("w_c4_addr", w_addr,              32'h0);
    check("w_c4_req",  {31'h0, w_req},      32'h1);

    // Stall in HOLD
    stall = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("st_valid", {31'h0, instr_valid}, 32'h1);
      check("st_instr", instr,                32'h0000_0513);
      check("st_pcout", pc_out,               32'h4);
      check("st_count", {16'h0, instr_count}, 32'h1);
      check("st_req",   {31'h0, imem_req},    32'h0);
      if (i == 5) stall = 1'b0;
      @(negedge clk);
    end
    check("st_count_after", {16'h0, instr_count}, 32'h2);
    check("st_next_req",    {31'h0, imem_req},    32'h1);
    check("st_next_addr",   imem_addr,            32'h8);
    check("st_valid_after", {31'h0, instr_valid}, 32'h0);

    // Redirect during WAIT, response latency 4
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    check("rw_req",    {31'h0, imem_req},    32'h0);
    check("rw_valid0", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    check("rw_valid1", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("rw_valid2", {31'h0, instr_valid}, 32'h0);
    check("rw_req2",   {31'h0, imem_req},    32'h1);
    check("rw_addr",   imem_addr,            32'h0000_0100);

    // Redirect coincident with response in WAIT
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    @(negedge clk);
    redirect = 1'b0; imem_rvalid = 1'b0;
    check("rc_req",   {31'h0, imem_req},    32'h1);
    check("rc_addr",  imem_addr,            32'h0000_0200);
    check("rc_valid", {31'h0, instr_valid}, 32'h0);
    check("rc_count", {16'h0, instr_count}, 32'h2);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("rh_valid",  {31'h0, instr_valid}, 32'h1);
    check("rh_pcout",  pc_out,               32'h0000_0200);
    check("rh_opcode", {25'h0, opcode},      32'h0000_006F);

    // Redirect with stall=0 in HOLD
    redirect = 1'b1; redirect_pc = 32'h0000_0303; stall = 1'b0;
    @(negedge clk);
    check("rh_valid2", {31'h0, instr_valid}, 32'h0);
    check("rh_count",  {16'h0, instr_count}, 32'h2);
    check("rh_req",    {31'h0, imem_req},    32'h1);
    check("rh_addr",   imem_addr,            32'h0000_0300);

    // Redirect in FETCH: issued request becomes stale
    redirect_pc = 32'h0000_0400;
    @(negedge clk);
    redirect = 1'b0;
    check("rf_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("rf_req2",  {31'h0, imem_req},    32'h1);
    check("rf_addr",  imem_addr,            32'h0000_0400);
    check("rf_valid", {31'h0, instr_valid}, 32'h0);
    check("rf_count", {16'h0, instr_count}, 32'h2);

    // Reset while in WAIT with memory responding through release
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    @(negedge clk);
    check("mr_req",   {31'h0, imem_req},    32'h0);
    check("mr_valid", {31'h0, instr_valid}, 32'h0);
    check("mr_count", {16'h0, instr_count}, 32'h0);
    check("mr_pcout", pc_out,               32'h0);
    rst_n = 1'b1;
    #1;
    check("mr_req2",  {31'h0, imem_req}, 32'h1);
    check("mr_addr",  imem_addr,         32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("mr_valid2", {31'h0, instr_valid}, 32'h0);
    check("mr_req3",   {31'h0, imem_req},    32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("mr_valid3", {31'h0, instr_valid}, 32'h1);
    check("mr_instr",  instr,                32'h0000_0013);
    check("mr_pcout2", pc_out,               32'h0);
    check("mr_count2", {16'h0, instr_count}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
